// File: rtl/spkr_buf_ctrl.sv
// Ping-pong sample-buffer controller: a producer fills one bank of a shared
// single-port RAM while the speaker plays the other; speaker reads win the port.
module spkr_buf_ctrl #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              spkr_done,
  output logic              spkr_update,
  output logic [DATA_W-1:0] spkr_sample,
  output logic              underrun,
  output logic              fill_req,
  input  logic              fill_valid,
  input  logic [DATA_W-1:0] fill_data,
  output logic              fill_ready,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W:0]   mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        full_banks
);

  localparam logic [ADDR_W-1:0] PTR_MAX = '1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_ISSUE = 2'd1,
    RD_WAIT  = 2'd2
  } state_t;

  state_t              state, state_nx;
  logic [1:0]          bank_full, bank_full_nx;
  logic                fill_bank, fill_bank_nx;
  logic                play_bank, play_bank_nx;
  logic [ADDR_W-1:0]   wr_ptr, wr_ptr_nx;
  logic [ADDR_W-1:0]   rd_ptr, rd_ptr_nx;
  logic                pend, pend_nx;
  logic                upd_nx, und_nx, load_rdata;
  logic                wr_fire;

  assign fill_req   = !bank_full[fill_bank];
  assign fill_ready = fill_req && (state != RD_ISSUE);
  assign wr_fire    = fill_valid && fill_ready;
  assign full_banks = bank_full;
  assign mem_wdata  = fill_data;

  always_comb begin
    mem_en   = 1'b0;
    mem_we   = 1'b0;
    mem_addr = {fill_bank, wr_ptr};
    if (state == RD_ISSUE) begin
      mem_en   = 1'b1;
      mem_addr = {play_bank, rd_ptr};
    end else if (wr_fire) begin
      mem_en = 1'b1;
      mem_we = 1'b1;
    end else begin
      mem_en = 1'b0;
    end
  end

  always_comb begin
    state_nx     = state;
    bank_full_nx = bank_full;
    fill_bank_nx = fill_bank;
    play_bank_nx = play_bank;
    wr_ptr_nx    = wr_ptr;
    rd_ptr_nx    = rd_ptr;
    pend_nx      = pend;
    upd_nx       = 1'b0;
    und_nx       = 1'b0;
    load_rdata   = 1'b0;
    case (state)
      IDLE: begin
        if (spkr_done || pend) begin
          pend_nx = 1'b0;
          if (bank_full[play_bank]) begin
            state_nx = RD_ISSUE;
          end else begin
            upd_nx = 1'b1;
            und_nx = 1'b1;
          end
        end
      end
      RD_ISSUE: begin
        state_nx  = RD_WAIT;
        rd_ptr_nx = rd_ptr + ADDR_W'(1);
        if (rd_ptr == PTR_MAX) begin
          bank_full_nx[play_bank] = 1'b0;
          play_bank_nx            = ~play_bank;
        end
        if (spkr_done) pend_nx = 1'b1;
      end
      RD_WAIT: begin
        state_nx   = IDLE;
        upd_nx     = 1'b1;
        load_rdata = 1'b1;
        if (spkr_done) pend_nx = 1'b1;
      end
      default: state_nx = IDLE;
    endcase
    // The play bank is always full and the fill bank never is, so a set here
    // cannot collide with the clear above.
    if (wr_fire) begin
      wr_ptr_nx = wr_ptr + ADDR_W'(1);
      if (wr_ptr == PTR_MAX) begin
        bank_full_nx[fill_bank] = 1'b1;
        fill_bank_nx            = ~fill_bank;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      bank_full   <= 2'b00;
      fill_bank   <= 1'b0;
      play_bank   <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      pend        <= 1'b0;
      spkr_update <= 1'b0;
      underrun    <= 1'b0;
      spkr_sample <= '0;
    end else begin
      state       <= state_nx;
      bank_full   <= bank_full_nx;
      fill_bank   <= fill_bank_nx;
      play_bank   <= play_bank_nx;
      wr_ptr      <= wr_ptr_nx;
      rd_ptr      <= rd_ptr_nx;
      pend        <= pend_nx;
      spkr_update <= upd_nx;
      underrun    <= und_nx;
      if (load_rdata)  spkr_sample <= mem_rdata;
      else if (und_nx) spkr_sample <= '0;
    end
  end

endmodule

// File: tb/tb_spkr_buf_ctrl.sv
// Scoreboard bench for spkr_buf_ctrl with a behavioural single-port RAM.
module tb_spkr_buf_ctrl;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 256;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              spkr_done = 1'b0;
  logic              spkr_update;
  logic [DATA_W-1:0] spkr_sample;
  logic              underrun;
  logic              fill_req;
  logic              fill_valid = 1'b0;
  logic [DATA_W-1:0] fill_data = '0;
  logic              fill_ready;
  logic              mem_en, mem_we;
  logic [ADDR_W:0]   mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata = '0;
  logic [1:0]        full_banks;

  logic [DATA_W-1:0] ram [0:2*DEPTH-1];
  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  typedef struct {
    logic [DATA_W-1:0] s;
    logic              u;
    int                c;
  } exp_t;
  exp_t exp_q[$];

  spkr_buf_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset), .spkr_done(spkr_done), .spkr_update(spkr_update),
    .spkr_sample(spkr_sample), .underrun(underrun), .fill_req(fill_req),
    .fill_valid(fill_valid), .fill_data(fill_data), .fill_ready(fill_ready),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .full_banks(full_banks)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata <= ram[mem_addr];
    end
  end

  // Scoreboard: every speaker update must match the oldest expected entry.
  always @(negedge clk) begin
    if (spkr_update) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_update: sample=%h underrun=%b cyc=%0d, none expected",
                 spkr_sample, underrun, cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (spkr_sample !== e.s || underrun !== e.u || cyc !== e.c) begin
          n_err++;
          $display("FAIL spkr_out: got sample=%h underrun=%b cyc=%0d, want sample=%h underrun=%b cyc=%0d",
                   spkr_sample, underrun, cyc, e.s, e.u, e.c);
        end
      end
    end else if (underrun) begin
      n_vec++;
      n_err++;
      $display("FAIL underrun_alone: underrun=1 without spkr_update, want 0");
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic pulse_done(input logic [DATA_W-1:0] s, input logic u, input int lat);
    exp_t e;
    e.s = s;
    e.u = u;
    e.c = cyc + lat;
    exp_q.push_back(e);
    spkr_done = 1'b1;
    tick();
    spkr_done = 1'b0;
    tick();
    tick();
  endtask

  task automatic fill(input int n, input logic [DATA_W-1:0] base, input logic bank0);
    for (int i = 0; i < n; i++) begin
      fill_valid = 1'b1;
      fill_data  = base + DATA_W'(i);
      #1;
      n_vec++;
      if (fill_ready !== 1'b1 || mem_we !== 1'b1 ||
          mem_addr !== {(i >= DEPTH) ? ~bank0 : bank0, i[7:0]}) begin
        n_err++;
        $display("FAIL fill_write[%0d]: ready=%b we=%b addr=%h", i, fill_ready, mem_we, mem_addr);
      end
      tick();
    end
    fill_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    n_vec++;
    if (spkr_update !== 1'b0 || underrun !== 1'b0 || spkr_sample !== 16'h0000 ||
        fill_req !== 1'b1 || full_banks !== 2'b00 || mem_en !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state: upd=%b und=%b smp=%h req=%b full=%b en=%b, want 0 0 0 1 00 0",
               spkr_update, underrun, spkr_sample, fill_req, full_banks, mem_en);
    end
    reset = 1'b0;
    pulse_done(16'h0000, 1'b1, 1);
    n_vec++;
    if (fill_req !== 1'b1 || full_banks !== 2'b00) begin
      n_err++;
      $display("FAIL underrun_status: req=%b full=%b, want 1 00", fill_req, full_banks);
    end
  endtask

  task automatic test_fill_play();
    do_reset();
    fill(DEPTH, 16'h0000, 1'b0);
    n_vec++;
    if (full_banks !== 2'b01 || fill_req !== 1'b1) begin
      n_err++;
      $display("FAIL fill_one_status: full=%b req=%b, want 01 1", full_banks, fill_req);
    end
    fill_valid = 1'b1;
    #1;
    n_vec++;
    if (mem_addr !== 9'h100) begin
      n_err++;
      $display("FAIL fill_bank_toggle: addr=%h, want 100", mem_addr);
    end
    fill_valid = 1'b0;
    for (int i = 0; i < DEPTH; i++) pulse_done(DATA_W'(i), 1'b0, 3);
    tick();
    n_vec++;
    if (full_banks !== 2'b00) begin
      n_err++;
      $display("FAIL play_drain: full=%b, want 00", full_banks);
    end
  endtask

  task automatic test_both_full();
    do_reset();
    fill(2 * DEPTH, 16'h5000, 1'b0);
    fill_valid = 1'b1;
    fill_data  = 16'hDEAD;
    #1;
    n_vec++;
    if (full_banks !== 2'b11 || fill_req !== 1'b0 || fill_ready !== 1'b0 || mem_en !== 1'b0) begin
      n_err++;
      $display("FAIL both_full: full=%b req=%b ready=%b en=%b, want 11 0 0 0",
               full_banks, fill_req, fill_ready, mem_en);
    end
    tick();
    fill_valid = 1'b0;
    for (int i = 0; i < DEPTH; i++) pulse_done(16'h5000 + DATA_W'(i), 1'b0, 3);
    n_vec++;
    if (full_banks !== 2'b10 || fill_req !== 1'b1) begin
      n_err++;
      $display("FAIL after_drain0: full=%b req=%b, want 10 1", full_banks, fill_req);
    end
    for (int i = 0; i < DEPTH; i++) pulse_done(16'h5100 + DATA_W'(i), 1'b0, 3);
    n_vec++;
    if (full_banks !== 2'b00) begin
      n_err++;
      $display("FAIL after_drain1: full=%b, want 00", full_banks);
    end
  endtask

  task automatic test_concurrent();
    int wcount = 0;
    int nreads = 0;
    int c = 0;
    logic issued_prev = 1'b0;
    logic issue_now;
    do_reset();
    fill(DEPTH, 16'h1000, 1'b0);
    while (wcount < DEPTH && c < 1000) begin
      issue_now  = (c % 3 == 0) && (nreads < 20);
      fill_valid = 1'b1;
      fill_data  = 16'h2000 + DATA_W'(wcount);
      spkr_done  = issue_now;
      if (issue_now) begin
        exp_t e;
        e.s = 16'h1000 + DATA_W'(nreads);
        e.u = 1'b0;
        e.c = cyc + 3;
        exp_q.push_back(e);
        nreads++;
      end
      #1;
      n_vec++;
      if (fill_ready !== !issued_prev) begin
        n_err++;
        $display("FAIL conc_ready c=%0d: ready=%b, want %b", c, fill_ready, !issued_prev);
      end
      if (issued_prev) begin
        n_vec++;
        if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== {1'b0, 8'(nreads - 1)}) begin
          n_err++;
          $display("FAIL conc_read c=%0d: en=%b we=%b addr=%h", c, mem_en, mem_we, mem_addr);
        end
      end else begin
        n_vec++;
        if (mem_we !== 1'b1 || mem_addr !== {1'b1, wcount[7:0]}) begin
          n_err++;
          $display("FAIL conc_write c=%0d: we=%b addr=%h, want 1 %h", c, mem_we, mem_addr,
                   {1'b1, wcount[7:0]});
        end
        wcount++;
      end
      issued_prev = issue_now;
      tick();
      c++;
    end
    fill_valid = 1'b0;
    spkr_done  = 1'b0;
    n_vec++;
    if (wcount !== DEPTH) begin
      n_err++;
      $display("FAIL conc_budget: wrote %0d, want %0d", wcount, DEPTH);
    end
    for (int i = 0; i < 4; i++) tick();
    n_vec++;
    if (full_banks !== 2'b11 || ram[9'h1FF] !== 16'h20FF || ram[9'h100] !== 16'h2000) begin
      n_err++;
      $display("FAIL conc_final: full=%b ram1ff=%h ram100=%h, want 11 20ff 2000",
               full_banks, ram[9'h1FF], ram[9'h100]);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    do_reset();
    fill(DEPTH, 16'h3000, 1'b0);
    e.s = 16'h3000; e.u = 1'b0; e.c = cyc + 3;
    exp_q.push_back(e);
    e.s = 16'h3001; e.u = 1'b0; e.c = cyc + 6;
    exp_q.push_back(e);
    spkr_done = 1'b1;
    tick();
    tick();
    tick();
    spkr_done = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    n_vec++;
    if (exp_q.size() !== 0) begin
      n_err++;
      $display("FAIL b2b_pending: %0d updates outstanding, want 0", exp_q.size());
    end
  endtask

  task automatic test_reset_mid_read();
    do_reset();
    fill(DEPTH, 16'h4000, 1'b0);
    spkr_done = 1'b1;
    tick();
    spkr_done = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_vec++;
    if (spkr_update !== 1'b0 || full_banks !== 2'b00 || fill_req !== 1'b1) begin
      n_err++;
      $display("FAIL mid_read_reset: upd=%b full=%b req=%b, want 0 00 1",
               spkr_update, full_banks, fill_req);
    end
    fill_valid = 1'b1;
    #1;
    n_vec++;
    if (mem_addr !== 9'h000) begin
      n_err++;
      $display("FAIL mid_read_ptr: addr=%h, want 000", mem_addr);
    end
    fill_valid = 1'b0;
    tick();
    pulse_done(16'h0000, 1'b1, 1);
    tick();
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, want completion");
    $fatal(1, "timeout");
  end

  initial begin
    tick();
    test_reset();
    test_fill_play();
    test_both_full();
    test_concurrent();
    test_back_to_back();
    test_reset_mid_read();
    tick();
    tick();
    n_vec++;
    if (exp_q.size() !== 0) begin
      n_err++;
      $display("FAIL missing_updates: %0d outstanding, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/spkr_buf_ctrl.md
# spkr_buf_ctrl

Ping-pong sample-buffer controller between the audio sample producer and the speaker output stage. It owns one shared single-port sample RAM split into two banks. It admits producer writes into the bank being filled and serves speaker sample requests from the bank being played. Speaker reads have priority on the RAM port. A request with no full bank is answered with silence and flagged as an underrun.

## Interface
- ADDR_W, 8, per-bank address width; bank depth DEPTH = 2^ADDR_W samples
- DATA_W, 16, sample width
- clk  in  1  system clock, all logic on posedge
- reset  in  1  synchronous, active-high; clears all state
- spkr_done  in  1  one-cycle pulse: speaker has consumed its current sample and wants the next
- spkr_update  out  1  one-cycle pulse: spkr_sample holds a new sample
- spkr_sample  out  DATA_W  registered sample to the speaker
- underrun  out  1  one-cycle pulse, coincident with spkr_update, when the supplied sample is silence
- fill_req  out  1  level: the fill bank is not full, so the producer may write
- fill_valid  in  1  producer has a sample on fill_data
- fill_data  in  DATA_W  producer sample
- fill_ready  out  1  combinational; a write is accepted when fill_valid && fill_ready
- mem_en  out  1  RAM port enable, combinational
- mem_we  out  1  RAM write enable, combinational
- mem_addr  out  ADDR_W+1  {bank, offset}, combinational
- mem_wdata  out  DATA_W  equals fill_data
- mem_rdata  in  DATA_W  RAM read data, valid the cycle after a read is issued
- full_banks  out  2  status: bank_full[1:0]

## Operation
- State: bank_full[1:0], fill_bank, play_bank, wr_ptr[ADDR_W-1:0], rd_ptr[ADDR_W-1:0], pend flag, speaker FSM {IDLE, RD_ISSUE, RD_WAIT}.
- Reset values: all flags 0, both bank pointers 0, both offset pointers 0, FSM IDLE, spkr_sample 0, spkr_update 0, underrun 0.
- fill_req = !bank_full[fill_bank].
- fill_ready = fill_req && (FSM != RD_ISSUE).
- Write handshake: mem_en=1, mem_we=1, mem_addr={fill_bank, wr_ptr}, then wr_ptr++.
  - If wr_ptr was DEPTH-1: wr_ptr wraps to 0, bank_full[fill_bank] is set, and fill_bank toggles.
- Speaker FSM:
  - IDLE: a request is (spkr_done || pend).
    - Request with bank_full[play_bank]=1 → RD_ISSUE, clear pend.
    - Request with bank_full[play_bank]=0 → stay in IDLE, clear pend, next cycle spkr_sample=0, spkr_update=1, underrun=1.
  - RD_ISSUE: mem_en=1, mem_we=0, mem_addr={play_bank, rd_ptr}, rd_ptr++ → RD_WAIT.
    - If rd_ptr was DEPTH-1: rd_ptr wraps to 0, bank_full[play_bank] is cleared, and play_bank toggles.
  - RD_WAIT: spkr_sample <= mem_rdata, spkr_update pulses next cycle → IDLE.
- spkr_done arriving in RD_ISSUE or RD_WAIT sets pend. A further spkr_done while pend=1 is dropped.
- The fill bank is never full and the play bank is always full when read, so they are distinct. A bank-full set and a bank-full clear in the same cycle always touch different banks, and both apply.
- No RAM access when idle: mem_en=0.

## Timing
- Read latency: spkr_done at cycle t in IDLE with the play bank full → RD_ISSUE at t+1, mem_rdata valid at t+2, spkr_update=1 with the new spkr_sample at t+3.
- Underrun latency: spkr_done at t → spkr_update=1, underrun=1, spkr_sample=0 at t+1.
- A pending request is served starting the cycle the FSM re-enters IDLE, so back-to-back requests are served every 3 cycles.
- The producer loses exactly the RD_ISSUE cycle. Sustained write throughput is 1 sample per cycle otherwise.
- spkr_sample holds its value between updates.
- Reset asserted mid-read: the next cycle is IDLE with no spkr_update. All bank contents are treated as empty.
- Status outputs bank_full and fill_req reflect an update the cycle after the causing handshake.

## Test plan
- After reset, issue spkr_done → at t+1: spkr_update=1, underrun=1, spkr_sample=0; fill_req=1, full_banks=00.
- Fill DEPTH samples 0..DEPTH-1 back-to-back → fill_ready is high throughout, full_banks=01, fill_bank=1. Then pulse spkr_done DEPTH times → samples 0..DEPTH-1 in order, each 3 cycles after its request, full_banks returns to 00.
- Fill both banks (2·DEPTH samples) → full_banks=11, fill_req=0, fill_ready=0. A further fill_valid is not accepted and the RAM is not written. After DEPTH reads, full_banks=10 and fill_req=1.
- Hold fill_valid high while pulsing spkr_done → fill_ready=0 only in RD_ISSUE cycles; no write is lost and the write address sequence is contiguous.
- spkr_done at t and t+1 → the second request is pended and served with spkr_update at t+6. A third spkr_done at t+2 is dropped.
- Assert reset during RD_WAIT → no spkr_update, full_banks=00, pointers=0. The next spkr_done yields an underrun.
